// File: rtl/max_finder.sv
// Classification stage: captures the output-layer neuron values, then scans
// them sequentially for the largest signed value and reports its index.
//
// state   | meaning
// COLLECT | capturing per-neuron valids into the buffer until every bit is set
// SCAN    | one buffer entry compared per cycle against the running maximum
// DONE    | one-cycle result pulse; mask cleared for the next frame
module max_finder #(
  parameter int neurons    = 10,
  parameter int dataWidth  = 16,
  parameter int indexWidth = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [neurons-1:0]             mf_in_valid,
  input  logic [neurons*dataWidth-1:0]   mf_in_data,
  output logic                           mf_out_valid,
  output logic [indexWidth-1:0]          mf_out_index,
  output logic [dataWidth-1:0]           mf_out_value,
  output logic                           mf_busy,
  output logic                           mf_overrun
);

  typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;

  localparam logic [indexWidth-1:0] LAST_IDX = indexWidth'(neurons - 1);

  state_t                        state_q, state_d;
  logic [neurons-1:0]            mask_q, mask_d;
  logic [indexWidth-1:0]         cnt_q, cnt_d;
  logic signed [dataWidth-1:0]   max_val_q, max_val_d;
  logic [indexWidth-1:0]         max_idx_q, max_idx_d;
  logic [dataWidth-1:0]          out_val_q, out_val_d;
  logic [indexWidth-1:0]         out_idx_q, out_idx_d;
  logic                          overrun_q, overrun_d;
  logic [neurons-1:0]            cap_we;
  logic signed [dataWidth-1:0]   cap_q [neurons];
  logic signed [dataWidth-1:0]   scan_val;
  logic                          take;

  // Capture buffer needs no reset; only entries with a mask bit are ever scanned.
  always_ff @(posedge clk) begin
    for (int i = 0; i < neurons; i++) begin
      if (cap_we[i]) cap_q[i] <= mf_in_data[i*dataWidth +: dataWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      mask_q    <= '0;
      cnt_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      out_val_q <= '0;
      out_idx_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      out_val_q <= out_val_d;
      out_idx_q <= out_idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign scan_val = cap_q[cnt_q];
  // Strictly greater keeps the lowest index on ties.
  assign take     = (cnt_q == '0) || (scan_val > max_val_q);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    out_val_d = out_val_q;
    out_idx_d = out_idx_q;
    cap_we    = '0;
    overrun_d = (state_q != COLLECT) && (|mf_in_valid);
    case (state_q)
      COLLECT: begin
        cap_we = mf_in_valid;
        mask_d = mask_q | mf_in_valid;
        if ((mask_q | mf_in_valid) == '1) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (take) begin
          max_val_d = scan_val;
          max_idx_d = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          // Result registers load from the final compare at the DONE-entry edge.
          state_d   = DONE;
          out_val_d = take ? scan_val : max_val_q;
          out_idx_d = take ? cnt_q : max_idx_q;
        end
      end
      DONE: begin
        mask_d  = '0;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign mf_out_valid = (state_q == DONE);
  assign mf_busy      = (state_q != COLLECT);
  assign mf_out_index = out_idx_q;
  assign mf_out_value = out_val_q;
  assign mf_overrun   = overrun_q;

endmodule

// File: tb/tb_max_finder.sv
// Directed bench for max_finder: hand-computed frames checked with immediate
// assertions, covering ties, negatives, staggered capture, overrun and reset.
module tb_max_finder;

  logic         clk;
  logic         rst;
  logic [9:0]   mf_in_valid;
  logic [159:0] mf_in_data;
  logic         mf_out_valid;
  logic [3:0]   mf_out_index;
  logic [15:0]  mf_out_value;
  logic         mf_busy;
  logic         mf_overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] v [10];

  max_finder #(.neurons(10), .dataWidth(16), .indexWidth(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mf_in_valid  (mf_in_valid),
    .mf_in_data   (mf_in_data),
    .mf_out_valid (mf_out_valid),
    .mf_out_index (mf_out_index),
    .mf_out_value (mf_out_value),
    .mf_busy      (mf_busy),
    .mf_overrun   (mf_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [9:0] bits);
    mf_in_valid = bits;
    for (int i = 0; i < 10; i++) mf_in_data[i*16 +: 16] = v[i];
  endtask

  // Called with the final valid already driven in the current cycle c.
  task automatic frame_check(input string tag, input logic [3:0] exp_idx, input logic [15:0] exp_val);
    int bad;
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      mf_in_valid = '0;
      if (mf_busy !== 1'b1 || mf_out_valid !== 1'b0) bad++;
    end
    chk({tag, " busy without pulse c+1..c+10"}, bad, 0);
    step();
    chk({tag, " valid at c+11"}, mf_out_valid, 1);
    chk({tag, " busy at c+11"}, mf_busy, 1);
    chk({tag, " index"}, mf_out_index, exp_idx);
    chk({tag, " value"}, mf_out_value, exp_val);
    step();
    chk({tag, " valid drops"}, mf_out_valid, 0);
    chk({tag, " busy drops"}, mf_busy, 0);
    chk({tag, " index held"}, mf_out_index, exp_idx);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    mf_in_valid = '0;
    mf_in_data = '0;
    step();
    step();
    chk("reset valid", mf_out_valid, 0);
    chk("reset index", mf_out_index, 0);
    chk("reset value", mf_out_value, 0);
    chk("reset busy", mf_busy, 0);
    chk("reset overrun", mf_overrun, 0);
    rst = 1'b0;
    step();
    chk("idle busy", mf_busy, 0);

    v = '{16'h0010, 16'h0020, 16'hFFFB, 16'h0100, 16'h0007,
          16'h0000, 16'h0001, 16'h7FFF, 16'hFFFF, 16'h0002};
    drive('1);
    frame_check("single-cycle", 4'd7, 16'h7FFF);

    v = '{16'h0001, 16'h0001, 16'h0001, 16'h0400, 16'h0001,
          16'h0400, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    drive('1);
    frame_check("tie", 4'd3, 16'h0400);

    // -100,-3,-50,-60,-70,-80,-90,-20,-10,-3
    v = '{16'hFF9C, 16'hFFFD, 16'hFFCE, 16'hFFC4, 16'hFFBA,
          16'hFFB0, 16'hFFA6, 16'hFFEC, 16'hFFF6, 16'hFFFD};
    drive('1);
    frame_check("negative", 4'd1, 16'hFFFD);

    for (int i = 0; i < 10; i++) v[i] = 16'h8000;
    drive('1);
    frame_check("all-min", 4'd0, 16'h8000);

    // Staggered: neuron 2 overwritten with the maximum between halves.
    v = '{16'h0200, 16'h0011, 16'h0003, 16'h0012, 16'h0013,
          16'h0014, 16'h0015, 16'h0016, 16'h0017, 16'h0400};
    drive(10'b00000_11111);
    step();
    mf_in_valid = '0;
    chk("stagger busy after half", mf_busy, 0);
    step();
    v[2] = 16'h0500;
    drive(10'b00000_00100);
    step();
    mf_in_valid = '0;
    chk("stagger busy after resend", mf_busy, 0);
    step();
    drive(10'b11111_00000);
    frame_check("staggered", 4'd2, 16'h0500);

    // Overrun during SCAN must not disturb the buffer or the result.
    v = '{16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0300,
          16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
    drive('1);
    step();
    mf_in_valid = '0;
    step();
    v[0] = 16'h7000;
    v[9] = 16'h7000;
    drive(10'b10000_00001);
    chk("overrun not yet", mf_overrun, 0);
    step();
    mf_in_valid = '0;
    chk("overrun pulse", mf_overrun, 1);
    step();
    chk("overrun single cycle", mf_overrun, 0);
    for (int k = 0; k < 7; k++) step();
    chk("overrun frame valid", mf_out_valid, 1);
    chk("overrun frame index", mf_out_index, 4);
    chk("overrun frame value", mf_out_value, 16'h0300);
    step();
    v = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
          16'h0001, 16'h0050, 16'h0001, 16'h0001, 16'h0002};
    drive(10'b01111_11111);
    step();
    mf_in_valid = '0;
    chk("mask empty after done", mf_busy, 0);
    step();
    chk("mask still partial", mf_busy, 0);
    drive(10'b10000_00000);
    frame_check("after overrun", 4'd6, 16'h0050);

    // Reset mid-scan abandons the frame and zeroes the outputs.
    v = '{16'h0005, 16'h0005, 16'h0123, 16'h0005, 16'h0005,
          16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
    drive('1);
    step();
    mf_in_valid = '0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midscan rst busy", mf_busy, 0);
    chk("midscan rst valid", mf_out_valid, 0);
    chk("midscan rst index", mf_out_index, 0);
    chk("midscan rst value", mf_out_value, 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (mf_out_valid === 1'b1 || mf_busy === 1'b1) pulses++;
    end
    chk("no activity after rst", pulses, 0);
    drive('1);
    frame_check("post-reset", 4'd2, 16'h0123);

    // Back-to-back: second frame driven in the cycle right after DONE.
    v = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
          16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A};
    drive('1);
    frame_check("b2b first", 4'd9, 16'h000A);
    v = '{16'h0100, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
          16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A};
    drive('1);
    frame_check("b2b second", 4'd0, 16'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/max_finder.md
Name: max_finder

Overview:
- Classification stage directly downstream of the 10-neuron output layer.
- Collects each output neuron's result, which may arrive in the same cycle or on different cycles, into a capture buffer.
- Once all neurons have reported, sequentially scans the buffer for the largest signed value.
- Emits the winning index (the recognised digit 0-9) and its value with a one-cycle valid pulse.

Parameters:
- neurons, 10, number of output neurons / classes scanned
- dataWidth, 16, width of each neuron output, signed two's complement
- indexWidth, 4, width of the result index; must satisfy 2^indexWidth >= neurons

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mf_in_valid  input  neurons  per-neuron valid; bit i qualifies slice i of mf_in_data
- mf_in_data  input  neurons*dataWidth  neuron i output at [i*dataWidth +: dataWidth]
- mf_out_valid  output  1  one-cycle pulse; result fields are valid
- mf_out_index  output  indexWidth  index of the maximum neuron
- mf_out_value  output  dataWidth  value of the maximum neuron
- mf_busy  output  1  high while in SCAN or DONE
- mf_overrun  output  1  one-cycle pulse; input valid was dropped

Behaviour:
- Reset (rst sampled high at an edge):
  - state=COLLECT, capture mask=0, scan counter=0.
  - mf_out_valid=0, mf_out_index=0, mf_out_value=0, mf_busy=0, mf_overrun=0.
  - Capture buffer contents are don't-care.
  - Reset overrides everything, including mid-SCAN: the scan is abandoned, no result is produced, and partial masks are discarded.
- State COLLECT:
  - For each i with mf_in_valid[i]=1: buf[i] <= slice i; mask[i] <= 1.
  - A repeated valid on an already-set bit overwrites buf[i]; the latest value wins and no error is flagged.
  - When (mask | mf_in_valid) is all ones at an edge, go to SCAN with cnt=0.
  - This includes every bit valid in a single cycle.
- State SCAN:
  - mf_busy=1.
  - Each cycle, compare buf[cnt] as signed against the running max.
  - If cnt==0 or buf[cnt] > max (strictly greater): max_val <= buf[cnt], max_idx <= cnt.
  - Ties therefore resolve to the lowest index.
  - cnt increments each cycle. At cnt==neurons-1 (after its compare), go to DONE.
  - SCAN lasts exactly neurons cycles.
- State DONE (one cycle):
  - mf_out_valid=1.
  - mf_out_index and mf_out_value are registered from max_idx/max_val at the DONE-entry edge.
  - Clear mask; return to COLLECT.
- Output holding: mf_out_index and mf_out_value hold their last result until the next DONE; they stay 0 after reset.
- Latency: if the final missing valid is sampled in cycle c, mf_out_valid is high in cycle c+neurons+1 (cycle c+11 at default).
- Throughput: one result per at most neurons+2 cycles.
- Overrun: any mf_in_valid bit high while in SCAN or DONE is dropped (buffer and mask unchanged), and mf_overrun pulses high in the following cycle.
- Back-to-back: a new frame may begin in the cycle immediately after DONE; valids in that cycle are captured normally.
- Arithmetic: signed comparison only; no arithmetic on values; value width is preserved.

Test Plan:
- Reset then single-cycle frame, values 0x0010,0x0020,-5,0x0100,7,0,1,0x7FFF,-1,2 -> mf_out_valid pulse in cycle c+11, index 7, value 0x7FFF, mf_busy high for cycles c+1..c+11.
- Tie: neurons 3 and 5 both 0x0400, others 0x0001 -> index 3, value 0x0400.
- All negative (-100,-3,-50,...,-3 at index 9) -> index 1, value 0xFFFD; 0x8000 at index 0 with all others 0x8000 -> index 0.
- Staggered valids: bits 0-4 in cycle 2, bits 5-9 in cycle 6, with neuron 2 re-sent in cycle 4 as 0x0500 (max) -> result index 2, value 0x0500, pulse in cycle 17.
- Overrun: valid bit 0 asserted during SCAN -> mf_overrun pulses next cycle; result unaffected; next frame's mask starts empty.
- Assert rst mid-SCAN -> no mf_out_valid; outputs 0; busy 0. A new full frame afterwards yields the correct result at nominal latency. Two back-to-back frames produce two pulses 12 cycles apart.
